// File: rtl/led_pio_blink.sv
// led_pio_blink: Avalon-MM LED output port with per-bit blink mask, prescaled blink phase and status register
//
// Ports:
//    clk          system clock, all state on its rising edge
//    reset        asynchronous active-high reset
//    address      register word address (0 DATA, 1 BLINK, 2 PERIOD, 3 STATUS, 4 OUTSET, 5 OUTCLEAR)
//    chipselect   slave select
//    write_n      active-low write strobe, qualified by chipselect
//    writedata    write data, only the low register-width bits are stored
//    readdata     combinational zero-extended read data, zero wait states
//    out_port     LED drive, DATA masked by BLINK during the dark phase
//    blink_phase  current blink phase
//
// Optional feature: define LED_PIO_BITSET_EN to enable atomic OUTSET (4) / OUTCLEAR (5) writes.
module led_pio_blink #(
   parameter int WIDTH        = 8,
   parameter int RESET_VALUE  = 0,
   parameter int PRESCALE_W   = 24,
   parameter int RESET_PERIOD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [31:0]          writedata,
   output logic [31:0]          readdata,
   output logic [WIDTH-1:0]     out_port,
   output logic                 blink_phase
);
   logic                  we;
   logic [WIDTH-1:0]      wd;
   logic [PRESCALE_W-1:0] wp;
   logic [WIDTH-1:0]      data_r, data_nxt, blink_r;
   logic [PRESCALE_W-1:0] period_r, cnt_r;
   logic                  phase_r;
   assign we = chipselect & ~write_n;
   assign wd = writedata[WIDTH-1:0];
   assign wp = writedata[PRESCALE_W-1:0];
   always_comb begin
`ifdef LED_PIO_BITSET_EN
      data_nxt = !we           ? data_r :
                 address == 0  ? wd :
                 address == 4  ? data_r | wd :
                 address == 5  ? data_r & ~wd : data_r;
`else
      data_nxt = (we && address == 0) ? wd : data_r;
`endif
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_r   <= WIDTH'(RESET_VALUE);
         blink_r  <= '0;
         period_r <= PRESCALE_W'(RESET_PERIOD);
         cnt_r    <= PRESCALE_W'(RESET_PERIOD);
         phase_r  <= 1'b0;
      end else begin
         data_r <= data_nxt;
         if (we && address == 1) blink_r <= wd;
         // A PERIOD write restarts the blink cycle and beats a coincident expiry
         if (we && address == 2) begin
            period_r <= wp;
            cnt_r    <= wp;
            phase_r  <= 1'b0;
         end else if (period_r == 0) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
         end else if (cnt_r != 0) begin
            cnt_r <= cnt_r - 1'b1;
         end else begin
            cnt_r   <= period_r;
            phase_r <= ~phase_r;
         end
      end
   end
   always_comb begin
      readdata = address == 0 ? 32'(data_r) :
                 address == 1 ? 32'(blink_r) :
                 address == 2 ? 32'(period_r) :
                 address == 3 ? {31'b0, phase_r} : 32'b0;
   end
   // Blinking bits go dark in phase 0 and follow DATA in phase 1
   assign out_port    = data_r & (~blink_r | {WIDTH{phase_r}});
   assign blink_phase = phase_r;
endmodule

// File: tb/tb_led_pio_blink.sv
// tb_led_pio_blink: scoreboard bench for led_pio_blink, expectations queued by stimulus and checked by a negedge monitor
module tb_led_pio_blink;
  typedef struct {
    int          id;
    logic [31:0] exp;
    string       name;
  } chk_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        blink_phase;
  chk_t        q[$];
  chk_t        c;
  logic [31:0] got;
  int          checks = 0;
  int          errors = 0;
  led_pio_blink #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .PRESCALE_W(24), .RESET_PERIOD(0)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .blink_phase(blink_phase)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      c = q.pop_front();
      got = c.id == 0 ? 32'(out_port) : c.id == 1 ? readdata : 32'(blink_phase);
      checks++;
      if (got !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
      end
    end
  end
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input logic [7:0] e, input string n);
    q.push_back('{0, 32'(e), n});
  endtask
  task automatic expect_phase(input logic e, input string n);
    q.push_back('{2, 32'(e), n});
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b1;
    q.push_back('{1, e, n});
    tick();
    chipselect = 1'b0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask
  initial begin
    logic ph;
    tick();
    expect_out(8'hA5, "out_in_reset");
    expect_phase(1'b0, "phase_in_reset");
    q.push_back('{1, 32'h0000_00A5, "rd_data_in_reset"});
    tick();
    reset = 1'b0;
    rd(0, 32'h0000_00A5, "rd_data_after_reset");
    rd(3, 32'h0, "rd_status_after_reset");
    wr(0, 32'hFFFF_FF3C);
    expect_out(8'h3C, "out_after_data_write");
    rd(0, 32'h0000_003C, "rd_data_upper_ignored");
    wr(0, 32'hFF);
    wr(1, 32'h0F);
    wr(2, 32'd3);
    address = 3;
    chipselect = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ph = ((k / 4) % 2) == 1;
      expect_out(ph ? 8'hFF : 8'hF0, "out_blink_p3");
      expect_phase(ph, "phase_blink_p3");
      q.push_back('{1, 32'(ph), "rd_status_p3"});
      tick();
    end
    chipselect = 1'b0;
    wr(2, 32'd5);
    for (int k = 0; k < 5; k++) begin
      expect_phase(1'b0, "phase_p5_counting");
      tick();
    end
    wr(2, 32'd2);
    for (int k = 0; k < 4; k++) begin
      expect_phase(k == 3, "phase_after_rewrite_p2");
      tick();
    end
    wr(2, 32'd0);
    for (int k = 0; k < 10; k++) begin
      expect_phase(1'b0, "phase_p0_stopped");
      expect_out(8'hF0, "out_p0_stopped");
      tick();
    end
    wr(2, 32'd1);
    tick();
    tick();
    expect_phase(1'b1, "phase_before_reset");
    expect_out(8'hFF, "out_before_reset");
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (out_port !== 8'hA5 || blink_phase !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_immediate: out %h phase %b", out_port, blink_phase);
    end
    expect_out(8'hA5, "out_async_reset");
    expect_phase(1'b0, "phase_async_reset");
    tick();
    reset = 1'b0;
    rd(1, 32'h0, "rd_blink_after_reset");
    rd(2, 32'h0, "rd_period_after_reset");
    rd(0, 32'hA5, "rd_data_after_reset2");
    wr(0, 32'h81);
    wr(4, 32'h18);
`ifdef LED_PIO_BITSET_EN
    rd(0, 32'h99, "rd_data_after_outset");
`else
    rd(0, 32'h81, "rd_data_outset_ignored");
`endif
    wr(5, 32'h81);
`ifdef LED_PIO_BITSET_EN
    rd(0, 32'h18, "rd_data_after_outclear");
    expect_out(8'h18, "out_after_outclear");
`else
    rd(0, 32'h81, "rd_data_outclear_ignored");
    expect_out(8'h81, "out_outclear_ignored");
`endif
    rd(4, 32'h0, "rd_outset_zero");
    rd(5, 32'h0, "rd_outclear_zero");
    wr(0, 32'h42);
    address = 0;
    writedata = 32'h55;
    chipselect = 1'b0;
    write_n = 1'b0;
    tick();
    write_n = 1'b1;
    rd(0, 32'h42, "rd_data_no_chipselect");
    wr(7, 32'hFFFF_FFFF);
    rd(7, 32'h0, "rd_reserved_zero");
    rd(0, 32'h42, "rd_data_after_reserved");
    rd(1, 32'h0, "rd_blink_after_reserved");
    rd(2, 32'h0, "rd_period_after_reserved");
    expect_phase(1'b0, "phase_after_reserved");
    tick();
    wr(2, 32'hFFFF_FFFF);
    rd(2, 32'h00FF_FFFF, "rd_period_upper_ignored");
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
